// File: rtl/div_pkg.sv
// div_pkg: shared state encodings and constants for the iterative divider.
package div_pkg;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on the {rem,quo} pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq_i,
  input  logic [WIDTH-1:0]   div_i,
  output logic [2*WIDTH-1:0] rq_o
);
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;
  // shifted remainder keeps its carry-out bit so the compare never truncates
  assign w_sh   = rq_i[2*WIDTH-1:WIDTH-1];
  assign w_diff = w_sh - {1'b0, div_i};
  assign rq_o   = w_diff[WIDTH] ? {w_sh[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b0}
                                : {w_diff[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b1};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring DIV/DIVU with stall/ready handshake and flush abort.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  input  logic               hold_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);
  div_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem, r_quo, r_div;
  logic               r_qneg, r_rneg;
  logic [2*WIDTH-1:0] r_result;
  logic [2*WIDTH-1:0] w_step;
  logic               w_neg1, w_neg2, w_last, w_launch, w_dz;
  logic [WIDTH-1:0]   w_abs1, w_abs2, w_rem_f, w_quo_f;

  assign w_neg1   = signed_i & opdata1_i[WIDTH-1];
  assign w_neg2   = signed_i & opdata2_i[WIDTH-1];
  assign w_abs1   = w_neg1 ? -opdata1_i : opdata1_i;
  assign w_abs2   = w_neg2 ? -opdata2_i : opdata2_i;
  assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
  assign w_launch = (r_state == DIV_IDLE) & start_i & ~annul_i;
  assign w_dz     = opdata2_i == '0;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rq_i  ({r_rem, r_quo}),
    .div_i (r_div),
    .rq_o  (w_step)
  );

  assign w_rem_f = r_rneg ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
  assign w_quo_f = r_qneg ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    if (annul_i) w_state_nxt = DIV_IDLE;
    else if (w_launch) w_state_nxt = w_dz ? DIV_DONE : DIV_BUSY;
    else if (r_state == DIV_BUSY) w_state_nxt = w_last ? DIV_DONE : DIV_BUSY;
    else if (r_state == DIV_DONE) w_state_nxt = hold_i ? DIV_DONE : DIV_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != DIV_DONE) r_result <= '0;
      if (w_launch) begin
        r_cnt  <= '0;
        r_rem  <= '0;
        r_quo  <= w_abs1;
        r_div  <= w_abs2;
        r_qneg <= w_neg1 ^ w_neg2;
        r_rneg <= w_neg1;
        if (w_dz) r_result <= {opdata1_i, WIDTH'(DIV_ZERO_QUOT)};
      end else if (r_state == DIV_BUSY && !annul_i) begin
        r_cnt <= r_cnt + 1'b1;
        {r_rem, r_quo} <= w_step;
        if (w_last) r_result <= {w_rem_f, w_quo_f};
      end
    end
  end

  // combinational so the hazard unit freezes the front end in the request cycle
  assign stall_o  = start_i & ~annul_i & ~rst & (r_state != DIV_DONE);
  assign ready_o  = r_state == DIV_DONE;
  assign result_o = r_result;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: vector table and scoreboard bench for the iterative divider.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, signed_i = 1'b0, annul_i = 1'b0, hold_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic        stall_o, ready_o;
  logic [63:0] result_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .hold_i    (hold_i),
    .stall_o   (stall_o),
    .ready_o   (ready_o),
    .result_o  (result_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    sb_q.push_back(exp);
    #1;
    chk("stall_at_start", {63'd0, stall_o}, 64'd1);
  endtask

  task automatic wait_ready(input int lat);
    int cyc = 0;
    bit got = 0;
    while (cyc < 40 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      if (ready_o) got = 1;
      else chk("stall_while_busy", {63'd0, stall_o}, 64'd1);
    end
    if (!got) begin
      n_errors++;
      $display("FAIL ready_timeout: got no ready within 40 cycles, required cycle %0d", lat);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      chk("latency", 64'(cyc), 64'(lat));
      chk("stall_at_ready", {63'd0, stall_o}, 64'd0);
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_empty: got result %h, required a pending entry", result_o);
      end else chk("result", result_o, sb_q.pop_front());
    end
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat);
    start_op(s, a, b, exp);
    wait_ready(lat);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", {63'd0, ready_o}, 64'd0);
    chk("idle_result", result_o, 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    bit          seen;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                     33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},      33};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},              33};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFF_FFFF},              1};
    vecs[4]  = '{1'b0, 32'd9,          32'd3,          {32'd0, 32'd3},                      33};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},              33};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},              33};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'd3},              33};
    vecs[8]  = '{1'b0, 32'd3,          32'd10,         {32'd3, 32'd0},                      33};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'hFFFF_FFFF},      1};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0, 32'd1},                      33};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'd2,          {32'd0, 32'h4000_0000},              33};

    #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_stall", {63'd0, stall_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 0) b = 32'd1;
      run_op(1'b0, a, b, {a % b, a / b}, 33);
    end

    // flush mid-operation: no ready, then a clean restart
    start_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    #1;
    chk("annul_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    void'(sb_q.pop_front());
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1;
    end
    chk("annul_no_ready", {63'd0, seen}, 64'd0);
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // hold at DONE keeps the result stable, IDLE right after release
    start_op(1'b0, 32'd1000, 32'd33, {32'd10, 32'd30});
    wait_ready(33);
    hold_i  = 1'b1;
    start_i = 1'b0;
    held    = result_o;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("hold_ready", {63'd0, ready_o}, 64'd1);
      chk("hold_result", result_o, held);
    end
    hold_i = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_release_ready", {63'd0, ready_o}, 64'd0);
    chk("hold_release_result", result_o, 64'd0);

    // asynchronous reset in the middle of an operation
    start_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", {63'd0, ready_o}, 64'd0);
    chk("async_rst_stall", {63'd0, stall_o}, 64'd0);
    chk("async_rst_result", result_o, 64'd0);
    void'(sb_q.pop_front());
    start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
